// File: rtl/arith_unit_serial.sv
// arith_unit_serial: bit-serial (CHUNK bits per cycle) adder/subtractor.
// An operation is captured in IDLE, its slices are added LSB first over
// N = WIDTH/CHUNK RUN cycles with a registered carry between slices, and the
// result and flags are published on the edge that enters DONE.
//
// Handshake: start is a request that is sampled only while the unit is idle
// (busy=0, done=0); there is no ready output, so a start seen in RUN or DONE is
// simply dropped. busy is high for exactly the N RUN cycles, and done pulses
// for one cycle once f/cout/ovf/zero/neg carry the new result. Those outputs
// then hold until the next result or reset. state_dbg exposes the FSM state.
// WIDTH must be an integer multiple of CHUNK.
module arith_unit_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       s,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0]       b_eff;
    logic [CHUNK-1:0]       slice_a;
    logic [CHUNK-1:0]       slice_b;
    logic [CHUNK:0]         slice_sum;
    logic                   msb_carry_in;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]       new_acc;

    // Second operand chosen by the op select: 0, B, ~B (subtract), all-ones (decrement).
    always_comb begin
        b_eff = '0;
        case (s)
            2'b00:   b_eff = '0;
            2'b01:   b_eff = b;
            2'b10:   b_eff = ~b;
            default: b_eff = '1;
        endcase
    end

    // One slice of the ripple sum; the new slice is shifted in at the top of acc,
    // so after N slices the LSB slice has arrived at bit 0.
    always_comb begin
        slice_a      = opa[CHUNK-1:0];
        slice_b      = opb[CHUNK-1:0];
        slice_sum    = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice's top bit; on the last slice this is the carry into bit WIDTH-1.
        msb_carry_in = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_sum[CHUNK-1];
        acc_cat      = {slice_sum[CHUNK-1:0], acc};
        new_acc      = acc_cat[WIDTH+CHUNK-1:CHUNK];
    end

    // FSM, operand shift registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            f     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_eff;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> CHUNK;
                    opb   <= opb >> CHUNK;
                    carry <= slice_sum[CHUNK];
                    acc   <= new_acc;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        f     <= new_acc;
                        cout  <= slice_sum[CHUNK];
                        ovf   <= msb_carry_in ^ slice_sum[CHUNK];
                        zero  <= ~|new_acc;
                        neg   <= new_acc[WIDTH-1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule
